// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - event handshake and per-voice player control bundle
interface voice_allocator_if #(
  parameter int NUM_VOICES    = 4,
  parameter int FREQ_RES_BITS = 8
);
  logic                                ev_valid;
  logic                                ev_ready;
  logic                                ev_note_on;
  logic [FREQ_RES_BITS-1:0]            ev_note;
  logic                                all_off;
  logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq;
  logic [NUM_VOICES-1:0]               voice_gate;
  logic [NUM_VOICES-1:0]               voice_retrig;
  logic                                dropped;
  logic                                steal;

  modport master (
    output ev_valid, ev_note_on, ev_note, all_off,
    input  ev_ready, voice_freq, voice_gate, voice_retrig, dropped, steal
  );

  modport slave (
    input  ev_valid, ev_note_on, ev_note, all_off,
    output ev_ready, voice_freq, voice_gate, voice_retrig, dropped, steal
  );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphony controller assigning note events to sample-player voices
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int FREQ_RES_BITS = 8,
  parameter int MAX_NOTE      = 132,
  parameter int AGE_BITS      = 8
) (
  input  logic             mclk,
  input  logic             rst,
  voice_allocator_if.slave bus
);
  localparam int                     IDX_W      = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_VOICES - 1);
  localparam logic [FREQ_RES_BITS:0] MAX_NOTE_W = (FREQ_RES_BITS + 1)'(MAX_NOTE);
  localparam logic [AGE_BITS-1:0]    AGE_MAX    = '1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
  state_t r_state, w_state_next;

  logic                     r_note_on;
  logic [FREQ_RES_BITS-1:0] r_note;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_match_found, r_free_found;
  logic [IDX_W-1:0]         r_match_idx, r_free_idx, r_old_idx;
  logic [AGE_BITS-1:0]      r_old_age;
  logic [FREQ_RES_BITS-1:0] r_freq [NUM_VOICES];
  logic [AGE_BITS-1:0]      r_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0]    r_gate, r_retrig;
  logic                     r_dropped, r_steal;

  logic                     w_ready, w_accept, w_illegal, w_steal;
  logic [NUM_VOICES-1:0]    w_off_mask;
  logic [IDX_W-1:0]         w_target;

  assign w_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept  = bus.ev_valid && w_ready;
  assign w_illegal = {1'b0, bus.ev_note} >= MAX_NOTE_W;

  // Note-on target priority: retrigger a matching voice, else a free one, else steal the oldest.
  assign w_steal  = !r_match_found && !r_free_found;
  assign w_target = r_match_found ? r_match_idx : (r_free_found ? r_free_idx : r_old_idx);

  always_comb begin
    w_off_mask = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_off_mask[v] = r_gate[v] && (r_freq[v] == r_note);
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_illegal) w_state_next = S_SCAN;
      S_SCAN:   if (r_idx == LAST_IDX) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (bus.all_off) w_state_next = S_IDLE;
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_note_on     <= 1'b0;
      r_note        <= '0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_free_found  <= 1'b0;
      r_match_idx   <= '0;
      r_free_idx    <= '0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
      r_gate        <= '0;
      r_retrig      <= '0;
      r_dropped     <= 1'b0;
      r_steal       <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_freq[v] <= '0;
        r_age[v]  <= '0;
      end
    end else begin
      r_retrig  <= '0;
      r_dropped <= 1'b0;
      r_steal   <= 1'b0;
      if (bus.all_off) begin
        // An event accepted on this very edge counts as in flight and is lost too.
        r_gate    <= '0;
        r_dropped <= (r_state != S_IDLE) || bus.ev_valid;
        for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_note_on     <= bus.ev_note_on;
              r_note        <= bus.ev_note;
              r_idx         <= '0;
              r_match_found <= 1'b0;
              r_free_found  <= 1'b0;
              r_old_age     <= '0;
              r_dropped     <= w_illegal;
            end
          end
          S_SCAN: begin
            if (!r_match_found && r_gate[r_idx] && (r_freq[r_idx] == r_note)) begin
              r_match_found <= 1'b1;
              r_match_idx   <= r_idx;
            end
            if (!r_free_found && !r_gate[r_idx]) begin
              r_free_found <= 1'b1;
              r_free_idx   <= r_idx;
            end
            if ((r_idx == '0) || (r_age[r_idx] > r_old_age)) begin
              r_old_idx <= r_idx;
              r_old_age <= r_age[r_idx];
            end
            r_idx <= r_idx + 1'b1;
          end
          S_COMMIT: begin
            if (r_note_on) begin
              r_steal <= w_steal;
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (IDX_W'(v) == w_target) begin
                  r_freq[v]   <= r_note;
                  r_gate[v]   <= 1'b1;
                  r_age[v]    <= '0;
                  r_retrig[v] <= 1'b1;
                end else if (r_gate[v] && (r_age[v] != AGE_MAX)) begin
                  r_age[v] <= r_age[v] + 1'b1;
                end
              end
            end else begin
              r_dropped <= ~|w_off_mask;
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_off_mask[v]) begin
                  r_gate[v] <= 1'b0;
                  r_age[v]  <= '0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ev_ready     = w_ready;
  assign bus.voice_gate   = r_gate;
  assign bus.voice_retrig = r_retrig;
  assign bus.dropped      = r_dropped;
  assign bus.steal        = r_steal;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_freq
    assign bus.voice_freq[g*FREQ_RES_BITS +: FREQ_RES_BITS] = r_freq[g];
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator with directed event vectors
module tb_voice_allocator;
  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  voice_allocator_if #(.NUM_VOICES(4), .FREQ_RES_BITS(8)) bus ();

  voice_allocator #(
    .NUM_VOICES(4), .FREQ_RES_BITS(8), .MAX_NOTE(132), .AGE_BITS(8)
  ) dut (
    .mclk(mclk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [3:0]  gate;
    logic [31:0] freq;
    logic [3:0]  retrig;
    logic        drop;
    logic        steal;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] gate, input logic [31:0] freq,
                      input logic [3:0] retrig, input logic drop, input logic steal);
    exp_t e;
    e.tag = tag; e.gate = gate; e.freq = freq; e.retrig = retrig; e.drop = drop; e.steal = steal;
    exp_q.push_back(e);
  endtask

  // Monitor: an output event is a ready rise or any pulse; each one pops one expectation.
  logic prev_ready = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      if (!rst && ((bus.ev_ready && !prev_ready) || bus.dropped || bus.steal || (|bus.voice_retrig))) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output gate=%b retrig=%b dropped=%b steal=%b",
                   bus.voice_gate, bus.voice_retrig, bus.dropped, bus.steal);
        end else begin
          e = exp_q.pop_front();
          chk({e.tag, "_gate"},   32'(bus.voice_gate),   32'(e.gate));
          chk({e.tag, "_freq"},   bus.voice_freq,        e.freq);
          chk({e.tag, "_retrig"}, 32'(bus.voice_retrig), 32'(e.retrig));
          chk({e.tag, "_dropped"}, 32'(bus.dropped),     32'(e.drop));
          chk({e.tag, "_steal"},  32'(bus.steal),        32'(e.steal));
        end
      end
      prev_ready = bus.ev_ready;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge mclk);
    while (!bus.ev_ready && n < 50) begin
      @(negedge mclk);
      n++;
    end
    if (!bus.ev_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  // Offers one event, then scrambles the event inputs to show they are ignored during scan.
  task automatic send(input logic on, input logic [7:0] note);
    wait_ready();
    bus.ev_valid   = 1'b1;
    bus.ev_note_on = on;
    bus.ev_note    = note;
    @(posedge mclk);
    #1;
    bus.ev_valid   = 1'b0;
    bus.ev_note_on = ~on;
    bus.ev_note    = 8'd99;
  endtask

  initial begin
    int n;
    bus.ev_valid   = 1'b0;
    bus.ev_note_on = 1'b0;
    bus.ev_note    = '0;
    bus.all_off    = 1'b0;

    repeat (3) @(negedge mclk);
    chk("reset_ev_ready", 32'(bus.ev_ready), 32'd0);
    push("reset", 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    push("on60", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd60}, 4'b0001, 1'b0, 1'b0);
    send(1'b1, 8'd60);
    n = 0;
    @(negedge mclk);
    while (!bus.ev_ready && n < 20) begin
      n++;
      @(negedge mclk);
    end
    chk("ready_low_cycles", 32'(n), 32'd5);

    push("on62", 4'b0011, {8'd0, 8'd0, 8'd62, 8'd60}, 4'b0010, 1'b0, 1'b0);
    send(1'b1, 8'd62);
    push("on62_match", 4'b0011, {8'd0, 8'd0, 8'd62, 8'd60}, 4'b0010, 1'b0, 1'b0);
    send(1'b1, 8'd62);
    push("off62", 4'b0001, {8'd0, 8'd0, 8'd62, 8'd60}, 4'b0000, 1'b0, 1'b0);
    send(1'b0, 8'd62);
    push("off50_miss", 4'b0001, {8'd0, 8'd0, 8'd62, 8'd60}, 4'b0000, 1'b1, 1'b0);
    send(1'b0, 8'd50);

    push("on140_illegal", 4'b0001, {8'd0, 8'd0, 8'd62, 8'd60}, 4'b0000, 1'b1, 1'b0);
    send(1'b1, 8'd140);
    @(negedge mclk);
    chk("illegal_ready_high", 32'(bus.ev_ready), 32'd1);

    push("all_off", 4'b0000, {8'd0, 8'd0, 8'd62, 8'd60}, 4'b0000, 1'b1, 1'b0);
    send(1'b1, 8'd65);
    @(posedge mclk);
    #1 bus.all_off = 1'b1;
    @(posedge mclk);
    #1 bus.all_off = 1'b0;

    push("fill60", 4'b0001, {8'd0,  8'd0,  8'd62, 8'd60}, 4'b0001, 1'b0, 1'b0);
    send(1'b1, 8'd60);
    push("fill62", 4'b0011, {8'd0,  8'd0,  8'd62, 8'd60}, 4'b0010, 1'b0, 1'b0);
    send(1'b1, 8'd62);
    push("fill64", 4'b0111, {8'd0,  8'd64, 8'd62, 8'd60}, 4'b0100, 1'b0, 1'b0);
    send(1'b1, 8'd64);
    push("fill67", 4'b1111, {8'd67, 8'd64, 8'd62, 8'd60}, 4'b1000, 1'b0, 1'b0);
    send(1'b1, 8'd67);
    push("steal72", 4'b1111, {8'd67, 8'd64, 8'd62, 8'd72}, 4'b0001, 1'b0, 1'b1);
    send(1'b1, 8'd72);

    push("b2b_on62", 4'b1111, {8'd67, 8'd64, 8'd62, 8'd72}, 4'b0010, 1'b0, 1'b0);
    push("b2b_off64", 4'b1011, {8'd67, 8'd64, 8'd62, 8'd72}, 4'b0000, 1'b0, 1'b0);
    wait_ready();
    bus.ev_valid   = 1'b1;
    bus.ev_note_on = 1'b1;
    bus.ev_note    = 8'd62;
    @(posedge mclk);
    #1;
    bus.ev_note_on = 1'b0;
    bus.ev_note    = 8'd64;
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (!bus.ev_ready && n < 20);
    @(posedge mclk);
    #1 bus.ev_valid = 1'b0;
    chk("b2b_accept_spacing", 32'(n), 32'd6);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge mclk);
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge mclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
